// File: rtl/suprloco_prom_arbiter_pkg.sv
// Shared types and helpers for the PROM read arbiter and its round-robin picker.
package suprloco_prom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2
    } arb_state_e;

    localparam int unsigned READ_LATENCY = 2;
    localparam int unsigned MAX_NREQ     = 8;
    localparam int unsigned IDX_W        = 3;

    // Returns {found, index}: first set request scanning upward from ptr, wrapping at nreq.
    function automatic logic [IDX_W:0] rr_search(input logic [MAX_NREQ-1:0] req,
                                                 input logic [IDX_W-1:0]    ptr,
                                                 input int unsigned         nreq);
        logic [IDX_W:0] res;
        int unsigned    idx;
        res = '0;
        for (int unsigned i = 0; i < MAX_NREQ; i++) begin
            idx = (32'(ptr) + i) % nreq;
            if (!res[IDX_W] && (i < nreq) && req[idx[IDX_W-1:0]]) begin
                res = {1'b1, idx[IDX_W-1:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/suprloco_prom_arbiter_if.sv
// Requester-side read bus of the shared PROM arbiter.
interface suprloco_prom_arbiter_if #(
    parameter int unsigned AW   = 10,
    parameter int unsigned DW   = 8,
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]    i_REQ;
    logic [NREQ*AW-1:0] i_REQ_ADDR;
    logic [NREQ-1:0]    o_ACK;
    logic [NREQ-1:0]    o_RVALID;
    logic [DW-1:0]      o_RDATA;

    modport master (output i_REQ, i_REQ_ADDR, input  o_ACK, o_RVALID, o_RDATA);
    modport slave  (input  i_REQ, i_REQ_ADDR, output o_ACK, o_RVALID, o_RDATA);
endinterface

// File: rtl/suprloco_rr_pick.sv
// Combinational round-robin picker: request vector + start pointer -> one-hot winner.
module suprloco_rr_pick
    import suprloco_prom_arb_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt_oh_c,
    output logic [IDX_W-1:0] gnt_idx_c,
    output logic             valid_c
);

    logic [IDX_W:0] res;

    always_comb begin
        res       = rr_search(MAX_NREQ'(req), ptr, NREQ);
        valid_c   = res[IDX_W];
        gnt_idx_c = res[IDX_W-1:0];
        gnt_oh_c  = valid_c ? (NREQ'(1) << gnt_idx_c) : '0;
    end

endmodule

// File: rtl/suprloco_prom_arbiter.sv
// Shares one program-loadable PROM between NREQ readers and the download stream.
// SUPRLOCO_PROM_ARB_FIXPRI_EN selects fixed lowest-index priority instead of round-robin.
module suprloco_prom_arbiter
    import suprloco_prom_arb_pkg::*;
#(
    parameter int unsigned AW   = 10,
    parameter int unsigned DW   = 8,
    parameter int unsigned NREQ = 3
) (
    input  logic                   i_MCLK,
    input  logic                   i_RST_n,
    input  logic                   i_DL_ACTIVE,
    input  logic [AW-1:0]          i_DL_ADDR,
    input  logic [DW-1:0]          i_DL_DATA,
    input  logic                   i_DL_WR,
    suprloco_prom_arbiter_if.slave rd_if,
    output logic                   o_BUSY,
    output logic [AW-1:0]          o_PROG_ADDR,
    output logic [DW-1:0]          o_PROG_DIN,
    output logic                   o_PROG_CS,
    output logic                   o_PROG_WR,
    output logic [AW-1:0]          o_ADDR,
    output logic                   o_RD,
    input  logic [DW-1:0]          i_DOUT
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [NREQ-1:0]  rvalid_q, rvalid_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             rd_q, rd_d;
    logic             busy_q, busy_d;
    logic [AW-1:0]    prog_addr_q, prog_addr_d;
    logic [DW-1:0]    prog_din_q, prog_din_d;
    logic             prog_cs_q, prog_cs_d;
    logic             prog_wr_q, prog_wr_d;

    logic [NREQ-1:0]  pick_oh_c;
    logic [IDX_W-1:0] pick_idx_c;
    logic             pick_valid_c;
    logic [IDX_W-1:0] pick_ptr_c;
    logic [IDX_W-1:0] next_ptr_c;
    logic             load_c;

`ifdef SUPRLOCO_PROM_ARB_FIXPRI_EN
    assign pick_ptr_c = '0;
    assign next_ptr_c = '0;
`else
    assign pick_ptr_c = ptr_q;
    assign next_ptr_c = (pick_idx_c == IDX_W'(NREQ - 1)) ? '0 : pick_idx_c + IDX_W'(1);
`endif

    suprloco_rr_pick #(.NREQ(NREQ)) u_pick (
        .req       (rd_if.i_REQ),
        .ptr       (pick_ptr_c),
        .gnt_oh_c  (pick_oh_c),
        .gnt_idx_c (pick_idx_c),
        .valid_c   (pick_valid_c)
    );

    // Next state: download ownership wins over any read grant at the same edge.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (i_DL_ACTIVE) begin
                    state_d = LOAD;
                end else if (pick_valid_c) begin
                    ack_d = pick_oh_c;
                    ptr_d = next_ptr_c;
                end
            end
            LOAD:    if (!i_DL_ACTIVE) state_d = SETTLE;
            SETTLE:  state_d = i_DL_ACTIVE ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase

        for (int unsigned k = 0; k < NREQ; k++) begin
            if (ack_d[k]) addr_d = rd_if.i_REQ_ADDR[k*AW +: AW];
        end

        rd_d        = |ack_d;
        rvalid_d    = ack_q;
        load_c      = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        prog_cs_d   = load_c;
        prog_wr_d   = load_c & i_DL_WR;
        prog_addr_d = load_c ? i_DL_ADDR : prog_addr_q;
        prog_din_d  = load_c ? i_DL_DATA : prog_din_q;
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            ack_q       <= '0;
            rvalid_q    <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            prog_addr_q <= '0;
            prog_din_q  <= '0;
            prog_cs_q   <= 1'b0;
            prog_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ack_q       <= ack_d;
            rvalid_q    <= rvalid_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            prog_addr_q <= prog_addr_d;
            prog_din_q  <= prog_din_d;
            prog_cs_q   <= prog_cs_d;
            prog_wr_q   <= prog_wr_d;
        end
    end

    // PROM output is already registered; gate it so the bus idles at zero.
    assign rd_if.o_ACK    = ack_q;
    assign rd_if.o_RVALID = rvalid_q;
    assign rd_if.o_RDATA  = (|rvalid_q) ? i_DOUT : '0;
    assign o_BUSY         = busy_q;
    assign o_PROG_ADDR    = prog_addr_q;
    assign o_PROG_DIN     = prog_din_q;
    assign o_PROG_CS      = prog_cs_q;
    assign o_PROG_WR      = prog_wr_q;
    assign o_ADDR         = addr_q;
    assign o_RD           = rd_q;

endmodule

// File: doc/suprloco_prom_arbiter.md
Name: suprloco_prom_arbiter

Overview:
Shares one single-port program-loadable PROM (registered read, i_RD-qualified, program write has priority) between NREQ read requesters and the ROM download stream. Round-robin read arbitration, pipelined one read issue per cycle, fixed 2-cycle request-to-data latency. Download takes the PROM exclusively while active. Sits between the video/sound fetch engines and each shared lookup PROM instance.

Parameters:
AW, 10, PROM address width
DW, 8, PROM data width
NREQ, 3, number of read requesters (2..8)

Ports:
i_MCLK  in  1  master clock, all logic on rising edge
i_RST_n  in  1  asynchronous active-low reset
i_DL_ACTIVE  in  1  download window for this PROM
i_DL_ADDR  in  AW  download byte address
i_DL_DATA  in  DW  download byte
i_DL_WR  in  1  download write strobe, one cycle per byte
i_REQ  in  NREQ  read request per requester, level, held until ack
i_REQ_ADDR  in  NREQ*AW  packed addresses, requester k at [k*AW +: AW]
o_ACK  out  NREQ  one-hot grant pulse, one cycle
o_RVALID  out  NREQ  one-hot read-data-valid pulse, one cycle
o_RDATA  out  DW  read data, valid when any o_RVALID bit set
o_BUSY  out  1  high while download owns the PROM (incl. settle cycle)
o_PROG_ADDR  out  AW  to PROM program address
o_PROG_DIN  out  DW  to PROM program data
o_PROG_CS  out  1  to PROM program chip select
o_PROG_WR  out  1  to PROM program write
o_ADDR  out  AW  to PROM read address
o_RD  out  1  to PROM read enable
i_DOUT  in  DW  from PROM registered data

Behaviour:
- Reset: all outputs 0, FSM=IDLE, RR pointer=0, in-flight pipeline cleared. Reset mid-read drops pending RVALID.
- FSM states: IDLE (arbitrating), LOAD (download), SETTLE (one cycle after LOAD). IDLE->LOAD when i_DL_ACTIVE=1 at an edge; LOAD->SETTLE when i_DL_ACTIVE=0; SETTLE->IDLE unconditionally (SETTLE->LOAD if i_DL_ACTIVE re-asserts).
- IDLE, cycle N: if any i_REQ set, winner w = first set bit searching from pointer upward mod NREQ. At edge ending N: o_ADDR<=addr[w], o_RD<=1, o_ACK<=onehot(w), pointer<=(w+1) mod NREQ. No request: o_RD<=0, o_ACK<=0, pointer unchanged.
- Cycle N+1: o_RD/o_ACK high; PROM captures. Cycle N+2: o_RVALID<=onehot(w) registered, o_RDATA=i_DOUT. Latency REQ-sample to data = 2 cycles.
- Back-to-back: new grant every cycle; requester still high in the ack cycle is re-eligible but RR ordering applies. Single requester held high gets ack every cycle.
- i_DL_ACTIVE has priority: no grant at any edge where it is sampled 1; o_RD<=0. Reads already issued complete their o_RVALID normally.
- LOAD: o_PROG_CS<=1; o_PROG_WR<=i_DL_WR; o_PROG_ADDR/DIN registered from i_DL_ADDR/DATA (1-cycle delay). i_DL_WR outside LOAD ignored. o_BUSY=1 in LOAD and SETTLE; SETTLE: PROG_CS=0, no grant.
- Requests pending during LOAD/SETTLE are held, not acked; arbitration resumes with unchanged pointer.
- o_ACK, o_RVALID at most one bit set; o_RD=|o_ACK always.

Optional Feature:
SUPRLOCO_PROM_ARB_FIXPRI_EN: defined -> fixed priority, lowest index wins, pointer unused (tied 0). Undefined -> round-robin as above. Latency and download behaviour identical.

Decomposition:
- Package suprloco_prom_arb_pkg: FSM state enum (IDLE, LOAD, SETTLE), READ_LATENCY=2 constant, onehot/rr-search helper function.
- One sub-module natural: suprloco_rr_pick (NREQ request vector + pointer -> one-hot winner, valid); combinational, reused by other arbiters.

Test Plan:
- Reset with all REQ=3'b111 -> outputs 0; after release ACK order 001,010,100,001; RVALID same order 2 cycles after each REQ sample.
- PROM preloaded ROM[k]=k^8'hA5; req1 addr 10'h155 single -> ACK=010 cycle+1, RVALID=010 with RDATA=8'hF0 cycle+2.
- DL_ACTIVE during streaming REQ0: last ACK completes RVALID, no ACK in LOAD/SETTLE; writes 0x000..0x0FF data=~addr -> readback addr 0x3C returns 8'hC3.
- DL_ACTIVE and REQ2 asserted same cycle -> no ACK, o_BUSY=1 next cycle; REQ2 acked exactly 1 cycle after SETTLE.
- i_DL_WR pulses with DL_ACTIVE=0 -> PROG_CS/WR stay 0, PROM unchanged.
- Reset asserted one cycle after ACK -> no RVALID ever emitted; with SUPRLOCO_PROM_ARB_FIXPRI_EN, REQ=111 held -> ACK=001 every cycle.
